// File: rtl/sd_cmd_resp_rx.sv
// SD CMD-line response receiver: waits for the card's start bit, shifts in a 48- or 136-bit
// response, checks CRC7 / end bit / index and presents RESP0..3 with sticky error flags.
module sd_cmd_resp_rx #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        ex_reset,
   input  logic        start,
   input  logic [1:0]  resp_type,
   input  logic        crc_chk_en,
   input  logic        idx_chk_en,
   input  logic [5:0]  cmd_index,
   input  logic        sd_cmd_in,
   output logic        busy,
   output logic        done,
   output logic        resp_en,
   output logic [31:0] resp0_out,
   output logic [31:0] resp1_out,
   output logic [31:0] resp2_out,
   output logic [31:0] resp3_out,
   output logic        timeout_err,
   output logic        crc_err,
   output logic        end_bit_err,
   output logic        idx_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, WAIT_START, RECV, EVAL} state_t;

   state_t            state_reg, state_next;
   logic [TW-1:0]     timer_reg, timer_next;
   logic [7:0]        count_reg, count_next;
   logic [127:0]      shift_reg, shift_next;
   logic [6:0]        crc_reg, crc_next;
   logic              long_reg, long_next;
   logic              crc_en_reg, crc_en_next;
   logic              idx_en_reg, idx_en_next;
   logic [5:0]        index_reg, index_next;
   logic              busy_reg, busy_next;
   logic              done_reg, done_next;
   logic              resp_en_reg, resp_en_next;
   logic [3:0][31:0]  resp_reg, resp_next;
   logic [3:0]        err_reg, err_next;   // {timeout, crc, end_bit, idx}

   logic [7:0]        bit_num;
   logic [7:0]        frame_len;
   logic              crc_cover;

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = b ^ c[6];
      return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

   // bit_num is the 1-based position of the bit being sampled; bit k lands in R[L-k].
   // The CRC is accumulated on the fly over R[47:8] or R[127:8].
   assign frame_len = long_reg ? 8'd136 : 8'd48;
   assign bit_num   = count_reg + 8'd1;
   assign crc_cover = long_reg ? ((bit_num >= 8'd9) && (bit_num <= 8'd128)) : (bit_num <= 8'd40);

   always_ff @(posedge clk or negedge ex_reset) begin
      if (!ex_reset) state_reg <= IDLE;
      else           state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge ex_reset) begin
      if (!ex_reset) begin
         timer_reg   <= '0;
         count_reg   <= '0;
         shift_reg   <= '0;
         crc_reg     <= '0;
         long_reg    <= 1'b0;
         crc_en_reg  <= 1'b0;
         idx_en_reg  <= 1'b0;
         index_reg   <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         resp_en_reg <= 1'b0;
         resp_reg    <= '0;
         err_reg     <= '0;
      end else begin
         timer_reg   <= timer_next;
         count_reg   <= count_next;
         shift_reg   <= shift_next;
         crc_reg     <= crc_next;
         long_reg    <= long_next;
         crc_en_reg  <= crc_en_next;
         idx_en_reg  <= idx_en_next;
         index_reg   <= index_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         resp_en_reg <= resp_en_next;
         resp_reg    <= resp_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      timer_next   = timer_reg;
      count_next   = count_reg;
      shift_next   = shift_reg;
      crc_next     = crc_reg;
      long_next    = long_reg;
      crc_en_next  = crc_en_reg;
      idx_en_next  = idx_en_reg;
      index_next   = index_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      resp_en_next = 1'b0;
      resp_next    = resp_reg;
      err_next     = err_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               if (resp_type != 2'b00) begin
                  state_next  = WAIT_START;
                  err_next    = '0;
                  timer_next  = '0;
                  busy_next   = 1'b1;
                  long_next   = (resp_type == 2'b01);
                  crc_en_next = crc_chk_en;
                  idx_en_next = idx_chk_en;
                  index_next  = cmd_index;
               end else begin
                  done_next = 1'b1;
               end
            end
         end
         WAIT_START: begin
            if (!sd_cmd_in) begin
               state_next = RECV;
               count_next = 8'd1;
               shift_next = {shift_reg[126:0], 1'b0};
               crc_next   = '0;
            end else if (timer_reg == TW'(TIMEOUT_CYCLES - 1)) begin
               state_next  = IDLE;
               err_next[3] = 1'b1;
               done_next   = 1'b1;
               busy_next   = 1'b0;
            end else begin
               timer_next = timer_reg + TW'(1);
            end
         end
         RECV: begin
            shift_next = {shift_reg[126:0], sd_cmd_in};
            count_next = bit_num;
            if (crc_cover) crc_next = crc7_step(crc_reg, sd_cmd_in);
            if (bit_num == frame_len) state_next = EVAL;
         end
         EVAL: begin
            // Registers load even on error; the flags tell software whether to trust them.
            state_next   = IDLE;
            done_next    = 1'b1;
            resp_en_next = 1'b1;
            busy_next    = 1'b0;
            err_next[2]  = crc_en_reg & (crc_reg != shift_reg[7:1]);
            err_next[1]  = ~shift_reg[0];
            err_next[0]  = idx_en_reg & ~long_reg & (shift_reg[45:40] != index_reg);
            resp_next[0] = shift_reg[39:8];
            resp_next[1] = long_reg ? shift_reg[71:40]  : 32'h0;
            resp_next[2] = long_reg ? shift_reg[103:72] : 32'h0;
            resp_next[3] = long_reg ? {8'h00, shift_reg[127:104]} : 32'h0;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign resp_en     = resp_en_reg;
   assign resp0_out   = resp_reg[0];
   assign resp1_out   = resp_reg[1];
   assign resp2_out   = resp_reg[2];
   assign resp3_out   = resp_reg[3];
   assign timeout_err = err_reg[3];
   assign crc_err     = err_reg[2];
   assign end_bit_err = err_reg[1];
   assign idx_err     = err_reg[0];

endmodule

// File: tb/tb_sd_cmd_resp_rx.sv
// Self-checking bench for sd_cmd_resp_rx: directed scenarios plus randomized responses
// compared against a bit-vector reference model with a long-division CRC7.
module tb_sd_cmd_resp_rx;

   logic        clk = 1'b0;
   logic        ex_reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  resp_type = 2'b00;
   logic        crc_chk_en = 1'b0;
   logic        idx_chk_en = 1'b0;
   logic [5:0]  cmd_index = 6'd0;
   logic        sd_cmd_in = 1'b1;
   logic        busy, done, resp_en;
   logic [31:0] resp0_out, resp1_out, resp2_out, resp3_out;
   logic        timeout_err, crc_err, end_bit_err, idx_err;

   int checks = 0;
   int errors = 0;

   sd_cmd_resp_rx #(.TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .ex_reset(ex_reset), .start(start), .resp_type(resp_type),
      .crc_chk_en(crc_chk_en), .idx_chk_en(idx_chk_en), .cmd_index(cmd_index),
      .sd_cmd_in(sd_cmd_in), .busy(busy), .done(done), .resp_en(resp_en),
      .resp0_out(resp0_out), .resp1_out(resp1_out), .resp2_out(resp2_out),
      .resp3_out(resp3_out), .timeout_err(timeout_err), .crc_err(crc_err),
      .end_bit_err(end_bit_err), .idx_err(idx_err)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // CRC7 as polynomial division: message (n bits, MSB first) times x^7 mod x^7+x^3+1.
   function automatic logic [6:0] ref_crc7(input logic [119:0] data, input int n);
      logic [7:0] rem;
      rem = '0;
      for (int i = n - 1; i >= -7; i--) begin
         rem = {rem[6:0], (i >= 0) ? data[i] : 1'b0};
         if (rem[7]) rem = rem ^ 8'h89;
      end
      return rem[6:0];
   endfunction

   function automatic logic [135:0] mk48(input logic [5:0] idx, input logic [31:0] arg, input logic endb);
      logic [39:0] m;
      m = {2'b00, idx, arg};
      return {88'h0, m, ref_crc7({80'h0, m}, 40), endb};
   endfunction

   function automatic logic [135:0] mk136(input logic [119:0] p, input logic endb);
      return {2'b00, 6'h3F, p, ref_crc7(p, 120), endb};
   endfunction

   task automatic run_resp(input bit long_t, input logic [135:0] r, input bit crc_en,
                           input bit idx_en, input logic [5:0] idx, input int pre_idle,
                           input bit poke_start, input string name);
      int L, cnt, n;
      bit early, got;
      logic [31:0] e0, e1, e2, e3;
      logic e_crc, e_end, e_idx;
      logic [119:0] cov;
      L = long_t ? 136 : 48;
      n = long_t ? 120 : 40;
      cov = long_t ? r[127:8] : {80'h0, r[47:8]};
      e0 = r[39:8];
      e1 = long_t ? r[71:40] : 32'h0;
      e2 = long_t ? r[103:72] : 32'h0;
      e3 = long_t ? {8'h00, r[127:104]} : 32'h0;
      e_crc = crc_en && (ref_crc7(cov, n) != r[7:1]);
      e_end = (r[0] != 1'b1);
      e_idx = idx_en && !long_t && (r[45:40] != idx);

      @(negedge clk);
      start = 1'b1; resp_type = long_t ? 2'b01 : 2'b10;
      crc_chk_en = crc_en; idx_chk_en = idx_en; cmd_index = idx; sd_cmd_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || {timeout_err, crc_err, end_bit_err, idx_err} !== 4'b0000) begin
         errors++;
         $display("FAIL %s arm: busy=%b errs=%b, required busy=1 errs=0000", name, busy,
                  {timeout_err, crc_err, end_bit_err, idx_err});
      end
      repeat (pre_idle) @(negedge clk);
      early = 0; cnt = 0;
      for (int k = 0; k < L; k++) begin
         sd_cmd_in = r[L - 1 - k];
         if (poke_start && k == 10) begin start = 1'b1; resp_type = 2'b00; end
         @(negedge clk);
         start = 1'b0;
         cnt++;
         if (done !== 1'b0) early = 1;
      end
      sd_cmd_in = 1'b1;
      got = 0;
      while (!got && cnt < L + 20) begin
         @(negedge clk);
         cnt++;
         if (done === 1'b1) got = 1;
      end
      checks++;
      if (early || !got || (cnt - 1) != L) begin
         errors++;
         $display("FAIL %s latency: early=%b got=%b cycles=%0d, required %0d", name, early, got,
                  cnt - 1, L);
      end
      checks++;
      if (resp_en !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s strobe: resp_en=%b busy=%b, required 1/0", name, resp_en, busy);
      end
      checks++;
      if ({resp3_out, resp2_out, resp1_out, resp0_out} !== {e3, e2, e1, e0}) begin
         errors++;
         $display("FAIL %s resp: got %h_%h_%h_%h, required %h_%h_%h_%h", name, resp3_out,
                  resp2_out, resp1_out, resp0_out, e3, e2, e1, e0);
      end
      checks++;
      if ({timeout_err, crc_err, end_bit_err, idx_err} !== {1'b0, e_crc, e_end, e_idx}) begin
         errors++;
         $display("FAIL %s errs: got %b, required %b", name,
                  {timeout_err, crc_err, end_bit_err, idx_err}, {1'b0, e_crc, e_end, e_idx});
      end
      $display("txn %s: L=%0d resp=%h_%h_%h_%h errs=%b", name, L, resp3_out, resp2_out,
               resp1_out, resp0_out, {timeout_err, crc_err, end_bit_err, idx_err});
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || resp_en !== 1'b0) begin
         errors++;
         $display("FAIL %s pulse: done=%b resp_en=%b, required 0/0", name, done, resp_en);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, resp_en, resp0_out, resp1_out, resp2_out, resp3_out,
           timeout_err, crc_err, end_bit_err, idx_err} !== '0) begin
         errors++;
         $display("FAIL reset: outputs not all zero (busy=%b resp0=%h)", busy, resp0_out);
      end
      $display("txn reset: outputs checked");
      ex_reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_r1();
      run_resp(0, mk48(6'd17, 32'h0000_0900, 1'b1), 1, 1, 6'd17, 3, 0, "r1");
      checks++;
      if (resp0_out !== 32'h0000_0900) begin
         errors++;
         $display("FAIL r1_const: resp0=%h, required 00000900", resp0_out);
      end
   endtask

   task automatic test_timeout_and_none();
      int cnt;
      bit got, saw_en;
      @(negedge clk);
      start = 1'b1; resp_type = 2'b10; sd_cmd_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cnt = 0; got = 0; saw_en = 0;
      while (!got && cnt < 100) begin
         @(negedge clk);
         cnt++;
         if (resp_en === 1'b1) saw_en = 1;
         if (done === 1'b1) got = 1;
      end
      checks++;
      if (!got || cnt != 64 || saw_en) begin
         errors++;
         $display("FAIL timeout: got=%b cycle=%0d resp_en_seen=%b, required done at 64, no resp_en",
                  got, cnt, saw_en);
      end
      checks++;
      if (timeout_err !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL timeout_flag: timeout_err=%b busy=%b, required 1/0", timeout_err, busy);
      end
      $display("txn timeout: done after %0d cycles", cnt);
      @(negedge clk);
      start = 1'b1; resp_type = 2'b00;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || resp_en !== 1'b0 || timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL none: done=%b busy=%b resp_en=%b timeout_err=%b, required 1/0/0/1",
                  done, busy, resp_en, timeout_err);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL none_pulse: done=%b, required 0", done);
      end
      $display("txn none: no-response command completed");
   endtask

   task automatic test_crc_end();
      logic [135:0] r;
      r = mk48(6'd17, 32'h0000_0900, 1'b1);
      r[20] = ~r[20];
      run_resp(0, r, 1, 1, 6'd17, 0, 0, "crc_flip");
      repeat (3) @(negedge clk);
      checks++;
      if (crc_err !== 1'b1) begin
         errors++;
         $display("FAIL crc_sticky: crc_err=%b, required 1", crc_err);
      end
      run_resp(0, mk48(6'd17, 32'h0000_0900, 1'b0), 1, 1, 6'd17, 2, 0, "end_bit");
   endtask

   task automatic test_index();
      run_resp(0, mk48(6'd18, 32'hDEAD_BEEF, 1'b1), 1, 1, 6'd17, 1, 0, "idx_on");
      run_resp(0, mk48(6'd18, 32'hDEAD_BEEF, 1'b1), 1, 0, 6'd17, 1, 0, "idx_off");
   endtask

   task automatic test_r2();
      run_resp(1, mk136(120'h11_2233_4455_6677_8899_AABB_CCDD_EEFF, 1'b1), 1, 1, 6'd2, 2, 0, "r2");
      checks++;
      if ({resp3_out, resp2_out, resp1_out, resp0_out} !==
          {32'h0011_2233, 32'h4455_6677, 32'h8899_AABB, 32'hCCDD_EEFF}) begin
         errors++;
         $display("FAIL r2_const: got %h_%h_%h_%h", resp3_out, resp2_out, resp1_out, resp0_out);
      end
   endtask

   task automatic test_start_boundary();
      run_resp(0, mk48(6'd7, 32'h1234_5678, 1'b1), 1, 1, 6'd7, 63, 0, "late_start");
   endtask

   task automatic test_reset_mid();
      logic [135:0] r;
      r = mk48(6'd17, 32'h0000_0900, 1'b1);
      @(negedge clk);
      start = 1'b1; resp_type = 2'b10; crc_chk_en = 1'b1; idx_chk_en = 1'b1; cmd_index = 6'd17;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         sd_cmd_in = r[47 - k];
         @(negedge clk);
      end
      #2 ex_reset = 1'b0;
      #1;
      checks++;
      if ({busy, done, resp_en, resp0_out, resp1_out, resp2_out, resp3_out,
           timeout_err, crc_err, end_bit_err, idx_err} !== '0) begin
         errors++;
         $display("FAIL reset_mid: outputs not zero (busy=%b resp0=%h resp1=%h)", busy,
                  resp0_out, resp1_out);
      end
      $display("txn reset_mid: async reset during receive");
      @(negedge clk);
      sd_cmd_in = 1'b1;
      ex_reset = 1'b1;
      run_resp(0, r, 1, 1, 6'd17, 1, 0, "after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 10; i++) begin
         bit long_t, crc_en, idx_en, poke;
         logic [5:0] idx, cidx;
         logic [31:0] a, b, c, d;
         logic [135:0] r;
         int mode, pos, L;
         long_t = ($urandom_range(0, 3) == 0);
         crc_en = $urandom_range(0, 1);
         idx_en = $urandom_range(0, 1);
         poke = $urandom_range(0, 1);
         idx = 6'($urandom_range(0, 63));
         cidx = ($urandom_range(0, 1) == 1) ? idx : 6'($urandom_range(0, 63));
         a = $urandom(); b = $urandom(); c = $urandom(); d = $urandom();
         r = long_t ? mk136({a[23:0], b, c, d}, 1'b1) : mk48(idx, a, 1'b1);
         L = long_t ? 136 : 48;
         mode = $urandom_range(0, 3);
         if (mode == 1) begin
            pos = $urandom_range(1, L - 2);
            r[pos] = ~r[pos];
         end else if (mode == 2) begin
            r[0] = 1'b0;
         end
         run_resp(long_t, r, crc_en, idx_en, cidx, $urandom_range(0, 20), poke, "random");
      end
   endtask

   initial begin
      test_reset();
      test_r1();
      test_timeout_and_none();
      test_crc_end();
      test_index();
      test_r2();
      test_start_boundary();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
